// File: rtl/probe_scan_sequencer.sv
// probe_scan_sequencer: time-multiplexes one colour probe across a table of raster coordinates
// Ports: CLK/RST (sync, active-high); V_CNT/H_CNT raster position; iR/iG/iB pixel colour;
//   iEN scan enable; iCFG_WE/iCFG_IDX/iCFG_H/iCFG_V coordinate-table write;
//   oR/oG/oB/oSLOT captured sample, oVALID/iREADY handshake; oBUSY high outside IDLE.
module probe_scan_sequencer #(
  parameter int NUM_PROBES   = 4,
  parameter int DWELL_FRAMES = 60,
  parameter int FRAME_H      = 0,
  parameter int FRAME_V      = 0,
  parameter int DEF_H        = 400,
  parameter int DEF_V        = 262,
  localparam int SW = NUM_PROBES > 1 ? $clog2(NUM_PROBES) : 1,
  localparam int CW = $clog2(DWELL_FRAMES + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [15:0]   V_CNT,
  input  logic [15:0]   H_CNT,
  input  logic [7:0]    iR,
  input  logic [7:0]    iG,
  input  logic [7:0]    iB,
  input  logic          iEN,
  input  logic          iCFG_WE,
  input  logic [SW-1:0] iCFG_IDX,
  input  logic [15:0]   iCFG_H,
  input  logic [15:0]   iCFG_V,
  output logic [7:0]    oR,
  output logic [7:0]    oG,
  output logic [7:0]    oB,
  output logic [SW-1:0] oSLOT,
  output logic          oVALID,
  input  logic          iREADY,
  output logic          oBUSY
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DWELL = 2'd3;
  logic [1:0]    state;
  logic [SW-1:0] slot;
  logic [CW-1:0] cnt;
  logic [15:0]   tbl_h [NUM_PROBES];
  logic [15:0]   tbl_v [NUM_PROBES];
  logic          hit_q, tick_q, hit_c, tick_c, hit, tick, last;
  // the pixel clock may be slower than CLK, so compares are edge-detected
  always_comb begin
    hit_c  = H_CNT == tbl_h[slot] && V_CNT == tbl_v[slot];
    tick_c = H_CNT == 16'(FRAME_H) && V_CNT == 16'(FRAME_V);
    hit    = hit_c & ~hit_q;
    tick   = tick_c & ~tick_q;
    last   = cnt == CW'(DWELL_FRAMES - 1);
  end
  assign oBUSY = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      slot   <= '0;
      cnt    <= '0;
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      oSLOT  <= '0;
      oVALID <= 1'b0;
      hit_q  <= 1'b0;
      tick_q <= 1'b0;
      for (int i = 0; i < NUM_PROBES; i++) begin
        tbl_h[i] <= 16'(DEF_H);
        tbl_v[i] <= 16'(DEF_V);
      end
    end else begin
      hit_q  <= hit_c;
      tick_q <= tick_c;
      // out-of-range indices match no entry and are dropped
      for (int i = 0; i < NUM_PROBES; i++)
        if (iCFG_WE && iCFG_IDX == SW'(i)) begin
          tbl_h[i] <= iCFG_H;
          tbl_v[i] <= iCFG_V;
        end
      case (state)
        IDLE: if (iEN) state <= ARM;
        ARM:
          if (!iEN) state <= IDLE;
          else if (hit) begin
            oR     <= iR;
            oG     <= iG;
            oB     <= iB;
            oSLOT  <= slot;
            oVALID <= 1'b1;
            state  <= HOLD;
          end
        HOLD:
          if (iREADY) begin
            oVALID <= 1'b0;
            cnt    <= '0;
            state  <= DWELL;
          end
        default:
          if (tick) begin
            if (last) begin
              slot  <= slot == SW'(NUM_PROBES - 1) ? '0 : slot + 1'b1;
              cnt   <= '0;
              state <= iEN ? ARM : IDLE;
            end else cnt <= cnt + 1'b1;
          end
      endcase
    end
  end
endmodule
